// File: rtl/sr_bank_sched_if.sv
// rtl/sr_bank_sched_if.sv - requester/bank-state bundle for the SR bank scheduler
// The master side is the pair of requesters; the slave side is the scheduler.
interface sr_bank_sched_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] a_r;
  logic             a_pulse;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] b_r;
  logic             b_pulse;
  logic             b_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             err_a;
  logic             err_b;
  logic             busy;

  modport master (
    output a_valid, a_s, a_r, a_pulse, b_valid, b_s, b_r, b_pulse,
    input  a_ready, b_ready, q, qbar, err_a, err_b, busy
  );

  modport slave (
    input  a_valid, a_s, a_r, a_pulse, b_valid, b_s, b_r, b_pulse,
    output a_ready, b_ready, q, qbar, err_a, err_b, busy
  );
endinterface

// File: rtl/sr_bank_sched.sv
// rtl/sr_bank_sched.sv - round-robin scheduler for an SR flip-flop bank
// Two requesters set/reset bits directly, or set bits for a timed pulse.
module sr_bank_sched #(
  parameter int WIDTH     = 8,
  parameter int PULSE_LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  sr_bank_sched_if.slave  bus
);

  typedef enum logic {IDLE, PULSE} state_t;

  localparam logic [7:0] CNT_INIT = 8'(PULSE_LEN - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [WIDTH-1:0] r_mask, w_mask_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic             r_last_b, w_last_b_nxt;
  logic             r_err_a, w_err_a_nxt;
  logic             r_err_b, w_err_b_nxt;

  logic             w_a_ready, w_b_ready, w_acc;
  logic [WIDTH-1:0] w_sel_s, w_sel_r;
  logic             w_sel_pulse, w_illegal;

  // Contention goes to whoever did not win last; r_last_b=1 means B won last.
  always_comb begin
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    if (!rst && r_state == IDLE) begin
      if (bus.a_valid && bus.b_valid) begin
        w_a_ready = r_last_b;
        w_b_ready = !r_last_b;
      end else begin
        w_a_ready = bus.a_valid;
        w_b_ready = bus.b_valid;
      end
    end
  end

  assign w_acc       = w_a_ready | w_b_ready;
  assign w_sel_s     = w_a_ready ? bus.a_s : bus.b_s;
  assign w_sel_r     = w_a_ready ? bus.a_r : bus.b_r;
  assign w_sel_pulse = w_a_ready ? bus.a_pulse : bus.b_pulse;
  assign w_illegal   = (|(w_sel_s & w_sel_r)) | (w_sel_pulse & (|w_sel_r));

  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_mask_nxt   = r_mask;
    w_cnt_nxt    = r_cnt;
    w_last_b_nxt = r_last_b;
    w_err_a_nxt  = 1'b0;
    w_err_b_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_last_b_nxt = w_b_ready;
          if (w_illegal) begin
            w_err_a_nxt = w_a_ready;
            w_err_b_nxt = w_b_ready;
          end else if (w_sel_pulse) begin
            w_q_nxt     = r_q | w_sel_s;
            w_mask_nxt  = w_sel_s;
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = PULSE;
          end else begin
            w_q_nxt = (r_q | w_sel_s) & ~w_sel_r;
          end
        end
      end
      PULSE: begin
        // Clearing the whole mask also drops bits that were already set.
        if (r_cnt == 8'd0) begin
          w_q_nxt     = r_q & ~r_mask;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_mask   <= '0;
      r_cnt    <= 8'd0;
      r_last_b <= 1'b1;
      r_err_a  <= 1'b0;
      r_err_b  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_mask   <= w_mask_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last_b <= w_last_b_nxt;
      r_err_a  <= w_err_a_nxt;
      r_err_b  <= w_err_b_nxt;
    end
  end

  assign bus.a_ready = w_a_ready;
  assign bus.b_ready = w_b_ready;
  assign bus.q       = r_q;
  assign bus.qbar    = ~r_q;
  assign bus.err_a   = r_err_a;
  assign bus.err_b   = r_err_b;
  assign bus.busy    = (r_state == PULSE);

endmodule

// File: tb/tb_sr_bank_sched.sv
// tb/tb_sr_bank_sched.sv - self-checking bench for sr_bank_sched
// Directed scenarios, then held-until-ready random traffic against a cycle model.
module tb_sr_bank_sched;

  localparam int W  = 8;
  localparam int PL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_bank_sched_if #(.WIDTH(W)) bus ();

  sr_bank_sched #(.WIDTH(W), .PULSE_LEN(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: bank contents, remaining busy cycles, pulse mask, fairness.
  logic [W-1:0] m_q;
  logic [W-1:0] m_mask;
  int           m_left;
  bit           m_last_b;
  bit           m_err_a, m_err_b;
  bit           g_acc_a, g_acc_b;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_mask = '0; m_left = 0; m_last_b = 1'b1;
    m_err_a = 1'b0; m_err_b = 1'b0;
  endtask

  task automatic exp_ready(output bit ea, output bit eb);
    ea = 1'b0; eb = 1'b0;
    if (!rst && m_left == 0) begin
      if (bus.a_valid && bus.b_valid) begin
        if (m_last_b) ea = 1'b1; else eb = 1'b1;
      end else begin
        ea = bus.a_valid; eb = bus.b_valid;
      end
    end
  endtask

  task automatic set_a(bit v, logic [W-1:0] s, logic [W-1:0] r, bit p);
    bus.a_valid = v; bus.a_s = s; bus.a_r = r; bus.a_pulse = p;
  endtask

  task automatic set_b(bit v, logic [W-1:0] s, logic [W-1:0] r, bit p);
    bus.b_valid = v; bus.b_s = s; bus.b_r = r; bus.b_pulse = p;
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge.
  task automatic cycle();
    bit ea, eb;
    logic [W-1:0] nq, s, r;
    bit p;
    #1;
    exp_ready(ea, eb);
    nq = ~m_q;
    chk("q", bus.q, m_q);
    chk("qbar", bus.qbar, nq);
    chk("busy", bus.busy, m_left > 0);
    chk("err_a", bus.err_a, m_err_a);
    chk("err_b", bus.err_b, m_err_b);
    chk("a_ready", bus.a_ready, ea);
    chk("b_ready", bus.b_ready, eb);
    g_acc_a = ea; g_acc_b = eb;
    @(posedge clk);
    m_err_a = 1'b0; m_err_b = 1'b0;
    if (rst) begin
      model_reset();
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_q = m_q & ~m_mask;
    end else if (ea || eb) begin
      s = ea ? bus.a_s : bus.b_s;
      r = ea ? bus.a_r : bus.b_r;
      p = ea ? bus.a_pulse : bus.b_pulse;
      m_last_b = eb;
      if ((s & r) != 0 || (p && r != 0)) begin
        m_err_a = ea; m_err_b = eb;
      end else if (p) begin
        m_q = m_q | s; m_mask = s; m_left = PL;
      end else begin
        m_q = (m_q | s) & ~r;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_cmd(output logic [W-1:0] s, output logic [W-1:0] r, output bit p);
    int k;
    s = W'($urandom);
    k = int'($urandom_range(0, 3));
    if (k == 0) r = W'($urandom);
    else if (k == 1) r = W'($urandom) & ~s;
    else r = '0;
    p = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    logic [W-1:0] s, r;
    bit p;
    set_a(1'b1, 8'h01, 8'h00, 1'b0);
    set_b(1'b1, 8'h02, 8'h00, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();

    chk("rst_q", bus.q, 8'h00);
    chk("rst_qbar", bus.qbar, 8'hFF);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready", {bus.a_ready, bus.b_ready}, 2'b00);
    cycle();
    rst = 1'b0;
    set_a(1'b0, 0, 0, 1'b0);
    set_b(1'b0, 0, 0, 1'b0);
    cycle();

    set_a(1'b1, 8'h0F, 8'h00, 1'b0); cycle(); set_a(1'b0, 0, 0, 1'b0);
    chk("set_q", bus.q, 8'h0F);
    chk("set_qbar", bus.qbar, 8'hF0);
    set_a(1'b1, 8'h00, 8'h03, 1'b0); cycle(); set_a(1'b0, 0, 0, 1'b0);
    chk("clr_q", bus.q, 8'h0C);

    set_a(1'b1, 8'h01, 8'h01, 1'b0); cycle(); set_a(1'b0, 0, 0, 1'b0);
    chk("ill_err_a", bus.err_a, 1'b1);
    chk("ill_q", bus.q, 8'h0C);
    cycle();
    chk("ill_err_a_drop", bus.err_a, 1'b0);

    rst = 1'b1; cycle(); rst = 1'b0;
    set_a(1'b1, 8'h01, 8'h00, 1'b0);
    set_b(1'b1, 8'h02, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", {bus.a_ready, bus.b_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      cycle();
    end
    set_a(1'b0, 0, 0, 1'b0);
    set_b(1'b0, 0, 0, 1'b0);
    chk("rr_q", bus.q, 8'h03);

    rst = 1'b1; cycle(); rst = 1'b0;
    set_b(1'b1, 8'h80, 8'h00, 1'b1); cycle(); set_b(1'b0, 0, 0, 1'b0);
    set_a(1'b1, 8'h01, 8'h00, 1'b0);
    for (int i = 0; i < PL; i++) begin
      chk("pls_busy", bus.busy, 1'b1);
      chk("pls_q", bus.q, 8'h80);
      #1;
      chk("pls_a_blocked", bus.a_ready, 1'b0);
      cycle();
    end
    chk("pls_end_busy", bus.busy, 1'b0);
    chk("pls_end_q", bus.q, 8'h00);
    #1;
    chk("pls_a_after", bus.a_ready, 1'b1);
    cycle(); set_a(1'b0, 0, 0, 1'b0);
    chk("pls_a_q", bus.q, 8'h01);

    set_a(1'b1, 8'h00, 8'h01, 1'b1); cycle(); set_a(1'b0, 0, 0, 1'b0);
    chk("plsill_err", bus.err_a, 1'b1);
    chk("plsill_busy", bus.busy, 1'b0);
    set_a(1'b1, 8'h10, 8'h00, 1'b1); cycle(); set_a(1'b0, 0, 0, 1'b0);
    chk("abort_busy1", bus.busy, 1'b1);
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("abort_q", bus.q, 8'h00);
    chk("abort_busy", bus.busy, 1'b0);
    set_a(1'b1, 8'h04, 8'h00, 1'b0);
    set_b(1'b1, 8'h08, 8'h00, 1'b0);
    #1;
    chk("abort_grant", {bus.a_ready, bus.b_ready}, 2'b10);
    cycle();

    g_acc_a = 1'b1; g_acc_b = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!bus.a_valid || g_acc_a) begin
        rand_cmd(s, r, p);
        set_a($urandom_range(0, 2) != 0, s, r, p);
      end
      if (!bus.b_valid || g_acc_b) begin
        rand_cmd(s, r, p);
        set_b($urandom_range(0, 2) != 0, s, r, p);
      end
      rst = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
